// File: rtl/ring_phase_monitor.sv
// Checker/decoder for the 4-bit rotate-left ring counter: binary phase, rotation count, sticky fault.
// Define RING_PHASE_MONITOR_AUTOSYNC_EN to let FAULT resync on a one-hot sample and Clr_err act in TRACK.
module ring_phase_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Ori,
    input  logic [3:0]       Q,
    input  logic             Clr_err,
    output logic [1:0]       Phase,
    output logic             Valid,
    output logic [CNT_W-1:0] Rot_cnt,
    output logic             Wrap,
    output logic             Err,
    output logic [1:0]       Err_code
);

    localparam logic [1:0] SYNC  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    localparam logic [1:0] CODE_NONE       = 2'b00;
    localparam logic [1:0] CODE_NOT_ONEHOT = 2'b01;
    localparam logic [1:0] CODE_BAD_STEP   = 2'b10;

    logic [1:0] state;
    logic [3:0] prev;
    logic [3:0] expected;
    logic       q_onehot;
    logic [1:0] q_index;

    always_comb begin
        expected = {prev[2:0], prev[3]};
        q_onehot = 1'b0;
        q_index  = 2'd0;
        case (Q)
            4'b0001: begin q_onehot = 1'b1; q_index = 2'd0; end
            4'b0010: begin q_onehot = 1'b1; q_index = 2'd1; end
            4'b0100: begin q_onehot = 1'b1; q_index = 2'd2; end
            4'b1000: begin q_onehot = 1'b1; q_index = 2'd3; end
            default: begin q_onehot = 1'b0; q_index = 2'd0; end
        endcase
    end

    // Phase, Rot_cnt and prev deliberately hold through a fault so the last good position stays visible.
    always_ff @(posedge Clk) begin
        if (Ori) begin
            state    <= SYNC;
            prev     <= 4'b0000;
            Phase    <= 2'd0;
            Valid    <= 1'b0;
            Rot_cnt  <= '0;
            Wrap     <= 1'b0;
            Err      <= 1'b0;
            Err_code <= CODE_NONE;
        end else begin
            Wrap <= 1'b0;
            case (state)
                SYNC: begin
                    if (q_onehot) begin
                        prev  <= Q;
                        Phase <= q_index;
                        Valid <= 1'b1;
                        state <= TRACK;
                    end
                end
                TRACK: begin
`ifdef RING_PHASE_MONITOR_AUTOSYNC_EN
                    if (Clr_err) begin
                        Err      <= 1'b0;
                        Err_code <= CODE_NONE;
                    end
`endif
                    if (!q_onehot) begin
                        Err      <= 1'b1;
                        Err_code <= CODE_NOT_ONEHOT;
                        Valid    <= 1'b0;
                        state    <= FAULT;
                    end else if (Q == expected) begin
                        prev  <= Q;
                        Phase <= q_index;
                        if (Q == 4'b0001) begin
                            Rot_cnt <= Rot_cnt + CNT_W'(1);
                            Wrap    <= 1'b1;
                        end
                    end else begin
                        Err      <= 1'b1;
                        Err_code <= CODE_BAD_STEP;
                        Valid    <= 1'b0;
                        state    <= FAULT;
                    end
                end
                FAULT: begin
                    if (Clr_err) begin
                        Err      <= 1'b0;
                        Err_code <= CODE_NONE;
                        state    <= SYNC;
                    end
`ifdef RING_PHASE_MONITOR_AUTOSYNC_EN
                    else if (q_onehot) begin
                        prev  <= Q;
                        Phase <= q_index;
                        Valid <= 1'b1;
                        state <= TRACK;
                    end
`endif
                end
                default: begin
                    state <= SYNC;
                    Valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Self-checking bench for ring_phase_monitor: directed vector table, corner sequences, random run vs reference model.
// Runs two instances (CNT_W=8 and CNT_W=2) on shared inputs so counter wrap is exercised quickly.
module tb_ring_phase_monitor;

    logic       Clk;
    logic       Ori;
    logic [3:0] Q;
    logic       Clr_err;

    logic [1:0] Phase, Phase2;
    logic       Valid, Valid2;
    logic [7:0] Rot_cnt;
    logic [1:0] Rot_cnt2;
    logic       Wrap, Wrap2;
    logic       Err, Err2;
    logic [1:0] Err_code, Err_code2;

    int checkCount = 0;
    int passCount  = 0;

    ring_phase_monitor #(.CNT_W(8)) dut (
        .Clk(Clk), .Ori(Ori), .Q(Q), .Clr_err(Clr_err),
        .Phase(Phase), .Valid(Valid), .Rot_cnt(Rot_cnt), .Wrap(Wrap),
        .Err(Err), .Err_code(Err_code)
    );

    ring_phase_monitor #(.CNT_W(2)) dut2 (
        .Clk(Clk), .Ori(Ori), .Q(Q), .Clr_err(Clr_err),
        .Phase(Phase2), .Valid(Valid2), .Rot_cnt(Rot_cnt2), .Wrap(Wrap2),
        .Err(Err2), .Err_code(Err_code2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: a ring position 0..3, an unbounded rotation tally and simple mode flags.
    bit mSynced, mFault, mWrap, mErr;
    int mIdx, mRot, mCode;

    function automatic int hotCount(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) n += v[i];
        return n;
    endfunction

    function automatic int hotPos(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic modelStep(input logic ori, input logic [3:0] q, input logic clr);
        bit oneHot;
        oneHot = (hotCount(q) == 1);
        if (ori) begin
            mSynced = 0; mFault = 0; mWrap = 0; mErr = 0;
            mIdx = 0; mRot = 0; mCode = 0;
            return;
        end
        mWrap = 0;
        if (mFault) begin
            if (clr) begin
                mErr = 0; mCode = 0; mFault = 0; mSynced = 0;
            end
`ifdef RING_PHASE_MONITOR_AUTOSYNC_EN
            else if (oneHot) begin
                mFault = 0; mSynced = 1; mIdx = hotPos(q);
            end
`endif
        end else if (!mSynced) begin
            if (oneHot) begin
                mSynced = 1; mIdx = hotPos(q);
            end
        end else begin
`ifdef RING_PHASE_MONITOR_AUTOSYNC_EN
            if (clr) begin
                mErr = 0; mCode = 0;
            end
`endif
            if (!oneHot) begin
                mErr = 1; mCode = 1; mFault = 1;
            end else if (hotPos(q) == (mIdx + 1) % 4) begin
                mIdx = hotPos(q);
                if (mIdx == 0) begin
                    mRot++;
                    mWrap = 1;
                end
            end else begin
                mErr = 1; mCode = 2; mFault = 1;
            end
        end
    endtask

    task automatic checkField(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input logic ori, input logic [3:0] q, input logic clr);
        Ori = ori; Q = q; Clr_err = clr;
        @(posedge Clk);
        modelStep(ori, q, clr);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int phase, input int valid, input int rot,
                               input int wrap, input int err, input int code);
        checkField({tag, ".Phase"},    int'(Phase),    phase);
        checkField({tag, ".Valid"},    int'(Valid),    valid);
        checkField({tag, ".Rot_cnt"},  int'(Rot_cnt),  rot);
        checkField({tag, ".Wrap"},     int'(Wrap),     wrap);
        checkField({tag, ".Err"},      int'(Err),      err);
        checkField({tag, ".Err_code"}, int'(Err_code), code);
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, mIdx, int'(mSynced && !mFault), mRot % 256, int'(mWrap), int'(mErr), mCode);
        checkField({tag, ".Rot_cnt2"}, int'(Rot_cnt2), mRot % 4);
        checkField({tag, ".Wrap2"},    int'(Wrap2),    int'(mWrap));
    endtask

    typedef struct {
        logic       ori;
        logic [3:0] q;
        logic       clr;
        int         phase;
        int         valid;
        int         rot;
        int         wrap;
        int         err;
        int         code;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic ori, input logic [3:0] q, input logic clr, input int phase,
                          input int valid, input int rot, input int wrap, input int err, input int code);
        vec_t v;
        v.ori = ori; v.q = q; v.clr = clr;
        v.phase = phase; v.valid = valid; v.rot = rot; v.wrap = wrap; v.err = err; v.code = code;
        vecs.push_back(v);
    endtask

    initial begin
        Ori = 1'b1; Q = 4'b0000; Clr_err = 1'b0;

        // Reset, clean run, not-one-hot fault, clear/resync, skip fault, reset+clear priority.
        addVec(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        addVec(0, 4'b0001, 0, 0, 1, 0, 0, 0, 0);
        addVec(0, 4'b0010, 0, 1, 1, 0, 0, 0, 0);
        addVec(0, 4'b0100, 0, 2, 1, 0, 0, 0, 0);
        addVec(0, 4'b1000, 0, 3, 1, 0, 0, 0, 0);
        addVec(0, 4'b0001, 0, 0, 1, 1, 1, 0, 0);
        addVec(0, 4'b0010, 0, 1, 1, 1, 0, 0, 0);
        addVec(0, 4'b0110, 0, 1, 0, 1, 0, 1, 1);
`ifdef RING_PHASE_MONITOR_AUTOSYNC_EN
        addVec(0, 4'b0000, 0, 1, 0, 1, 0, 1, 1);
        addVec(0, 4'b0000, 0, 1, 0, 1, 0, 1, 1);
        addVec(0, 4'b0000, 0, 1, 0, 1, 0, 1, 1);
`else
        addVec(0, 4'b0000, 0, 1, 0, 1, 0, 1, 1);
        addVec(0, 4'b1000, 0, 1, 0, 1, 0, 1, 1);
        addVec(0, 4'b1000, 0, 1, 0, 1, 0, 1, 1);
`endif
        addVec(0, 4'b0100, 1, 1, 0, 1, 0, 0, 0);
        addVec(0, 4'b1000, 0, 3, 1, 1, 0, 0, 0);
        addVec(0, 4'b0001, 0, 0, 1, 2, 1, 0, 0);
        addVec(0, 4'b0010, 0, 1, 1, 2, 0, 0, 0);
        addVec(0, 4'b1000, 0, 1, 0, 2, 0, 1, 2);
        addVec(1, 4'b0001, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ori, vecs[i].q, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].phase, vecs[i].valid, vecs[i].rot,
                        vecs[i].wrap, vecs[i].err, vecs[i].code);
        end

        // Hold and reverse from 0010, then reset inside FAULT and resync after it drops.
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0010, 0); checkOutput("holdSync", 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 4'b0010, 0); checkOutput("hold",     1, 0, 0, 0, 1, 2);
        applyStimulus(0, 4'b0000, 1); checkOutput("holdClr",  1, 0, 0, 0, 0, 0);
        applyStimulus(0, 4'b0010, 0); checkOutput("revSync",  1, 1, 0, 0, 0, 0);
        applyStimulus(0, 4'b0001, 0); checkOutput("reverse",  1, 0, 0, 0, 1, 2);
        applyStimulus(1, 4'b0100, 0); checkOutput("oriFault", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 4'b0100, 0); checkOutput("resync",   2, 1, 0, 0, 0, 0);

        // Five full rotations on the 2-bit counter instance.
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0001, 0);
        checkField("wrapSync.Rot_cnt2", int'(Rot_cnt2), 0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 4'b0010, 0);
            checkField($sformatf("wrapMid%0d.Wrap2", k), int'(Wrap2), 0);
            applyStimulus(0, 4'b0100, 0);
            applyStimulus(0, 4'b1000, 0);
            applyStimulus(0, 4'b0001, 0);
            checkField($sformatf("wrap%0d.Rot_cnt2", k), int'(Rot_cnt2), k % 4);
            checkField($sformatf("wrap%0d.Wrap2", k),    int'(Wrap2),    1);
            checkField($sformatf("wrap%0d.Rot_cnt", k),  int'(Rot_cnt),  k);
        end

`ifdef RING_PHASE_MONITOR_AUTOSYNC_EN
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0001, 0);
        applyStimulus(0, 4'b0100, 0); checkOutput("autoFault", 0, 0, 0, 0, 1, 2);
        applyStimulus(0, 4'b0100, 0); checkOutput("autoSync",  2, 1, 0, 0, 1, 2);
        applyStimulus(0, 4'b1000, 1); checkOutput("autoClr",   3, 1, 0, 0, 0, 0);
`endif

        // Random run, mostly legal steps with occasional faults, clears and resets.
        applyStimulus(1, 4'b0000, 0);
        checkModel("rndReset");
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [3:0] q;
            logic ori, clr;
            r = $urandom_range(0, 15);
            if (r < 11)      q = 4'(1 << ((mIdx + 1) % 4));
            else if (r < 13) q = 4'($urandom);
            else             q = 4'(1 << $urandom_range(0, 3));
            clr = ($urandom_range(0, 7) == 0);
            ori = ($urandom_range(0, 199) == 0);
            applyStimulus(ori, q, clr);
            checkModel($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
